// File: rtl/blinky_led.sv
// Free-running LED blinker: a CBITS-wide up-counter whose MSB drives the LED,
// giving a 50% duty square wave with a period of 2^CBITS clocks.
`timescale 1ns/1ps
module blinky_led #(
   parameter int CBITS          = 26,
   parameter bit LED_ACTIVE_LOW = 1'b0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   output logic             o_led,
   output logic             o_wrap,
   output logic [CBITS-1:0] o_count
);

   if (CBITS < 2 || CBITS > 32) begin : g_bad_cbits
      $fatal(1, "blinky_led: CBITS=%0d outside legal range 2..32", CBITS);
   end

   localparam logic [CBITS-1:0] CNT_ONE  = CBITS'(1);
   localparam logic [CBITS-1:0] CNT_LAST = '1;

   logic [CBITS-1:0] cnt;

   // The increment is exactly CBITS wide, so all-ones rolls straight to zero.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_ONE;
      end
   end

   // LED comes from a single register bit so it cannot glitch.
   assign o_count = cnt;
   assign o_led   = cnt[CBITS-1] ^ LED_ACTIVE_LOW;
   assign o_wrap  = (cnt == CNT_LAST);

endmodule

// File: tb/tb_blinky_led.sv
// Self-checking bench for blinky_led: four instances (CBITS 4, 4 active-low, 2, 8)
// share clock and reset and are compared against an edges-since-release model.
`timescale 1ns/1ps
module tb_blinky_led;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic [3:0] c4, c4n;
   logic [1:0] c2;
   logic [7:0] c8;
   logic       l4, l4n, l2, l8;
   logic       w4, w4n, w2, w8;

   blinky_led #(.CBITS(4), .LED_ACTIVE_LOW(1'b0)) u4 (
      .i_clk(clk), .i_rst_n(rst_n), .o_led(l4), .o_wrap(w4), .o_count(c4));
   blinky_led #(.CBITS(4), .LED_ACTIVE_LOW(1'b1)) u4n (
      .i_clk(clk), .i_rst_n(rst_n), .o_led(l4n), .o_wrap(w4n), .o_count(c4n));
   blinky_led #(.CBITS(2), .LED_ACTIVE_LOW(1'b0)) u2 (
      .i_clk(clk), .i_rst_n(rst_n), .o_led(l2), .o_wrap(w2), .o_count(c2));
   blinky_led #(.CBITS(8), .LED_ACTIVE_LOW(1'b0)) u8 (
      .i_clk(clk), .i_rst_n(rst_n), .o_led(l8), .o_wrap(w8), .o_count(c8));

   int checks = 0;
   int errors = 0;
   int edges  = 0;   // rising edges seen with reset released since last reset

   typedef struct {
      int         adv;
      logic [3:0] cnt;
      logic       led;
      logic       wrap;
   } vec_t;
   vec_t tbl[8];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] m_cnt(input int c);
      return 32'(edges % (1 << c));
   endfunction

   function automatic logic [31:0] m_led(input int c, input bit al);
      logic lvl;
      lvl = ((edges % (1 << c)) >= (1 << (c - 1)));
      return {31'd0, lvl ^ al};
   endfunction

   function automatic logic [31:0] m_wrap(input int c);
      return {31'd0, (edges % (1 << c)) == ((1 << c) - 1)};
   endfunction

   task automatic check_all();
      check("cnt4",  32'(c4),  m_cnt(4));
      check("led4",  32'(l4),  m_led(4, 1'b0));
      check("wrap4", 32'(w4),  m_wrap(4));
      check("cnt4n", 32'(c4n), m_cnt(4));
      check("led4n", 32'(l4n), m_led(4, 1'b1));
      check("wrap4n",32'(w4n), m_wrap(4));
      check("cnt2",  32'(c2),  m_cnt(2));
      check("led2",  32'(l2),  m_led(2, 1'b0));
      check("wrap2", 32'(w2),  m_wrap(2));
      check("cnt8",  32'(c8),  m_cnt(8));
      check("led8",  32'(l8),  m_led(8, 1'b0));
      check("wrap8", 32'(w8),  m_wrap(8));
   endtask

   // Ends 1 ns after a rising edge.
   task automatic tick();
      @(posedge clk);
      if (rst_n) edges++;
      #1;
   endtask

   // Called 1 ns after an edge: asserts reset mid-cycle and checks before the next edge.
   task automatic assert_rst();
      #2 rst_n = 1'b0;
      edges = 0;
      #1;
      check_all();
   endtask

   task automatic release_rst();
      #1 rst_n = 1'b1;
   endtask

   initial begin
      int pulses, first_rise, r, hold;
      int last_l2, last_l8, last_w2, last_w8, n_l2, n_l8, n_w2, n_w8;
      logic prev_l4, prev_l2, prev_l8;

      tbl[0] = '{1,  4'd1,  1'b0, 1'b0};
      tbl[1] = '{6,  4'd7,  1'b0, 1'b0};
      tbl[2] = '{1,  4'd8,  1'b1, 1'b0};
      tbl[3] = '{7,  4'd15, 1'b1, 1'b1};
      tbl[4] = '{1,  4'd0,  1'b0, 1'b0};
      tbl[5] = '{15, 4'd15, 1'b1, 1'b1};
      tbl[6] = '{1,  4'd0,  1'b0, 1'b0};
      tbl[7] = '{3,  4'd3,  1'b0, 1'b0};

      // Power-up reset, checked before any clock edge
      #1 rst_n = 1'b0;
      #2 check_all();
      check("rst_led4n", 32'(l4n), 32'd1);
      tick();
      release_rst();

      // Table-driven vectors, cumulative edges after release
      for (int i = 0; i < 8; i++) begin
         repeat (tbl[i].adv) tick();
         check($sformatf("tbl%0d_cnt", i),  32'(c4),  32'(tbl[i].cnt));
         check($sformatf("tbl%0d_led", i),  32'(l4),  32'(tbl[i].led));
         check($sformatf("tbl%0d_wrap", i), 32'(w4),  32'(tbl[i].wrap));
         check($sformatf("tbl%0d_ledn", i), 32'(l4n), 32'(!tbl[i].led));
      end

      // 100 clocks from release: count, LED shape, wrap pulses
      assert_rst();
      release_rst();
      pulses = 0; first_rise = -1; prev_l4 = l4;
      for (int i = 1; i <= 100; i++) begin
         tick();
         check_all();
         if (w4) pulses++;
         if (l4 && !prev_l4 && first_rise < 0) first_rise = i;
         prev_l4 = l4;
      end
      check("wrap_pulses_100", 32'(pulses), 32'd6);
      check("first_rise", 32'(first_rise), 32'd8);

      // Mid-operation reset at count 11
      assert_rst();
      release_rst();
      repeat (11) tick();
      check("cnt_at_11", 32'(c4), 32'd11);
      assert_rst();
      check("midrst_cnt", 32'(c4), 32'd0);
      check("midrst_led", 32'(l4), 32'd0);
      release_rst();
      first_rise = -1; prev_l4 = l4;
      for (int i = 1; i <= 40 && first_rise < 0; i++) begin
         tick();
         if (l4 && !prev_l4) first_rise = i;
         prev_l4 = l4;
      end
      check("rise_after_midrst", 32'(first_rise), 32'd8);

      // Reset held across 5 edges
      assert_rst();
      for (int i = 0; i < 5; i++) begin
         tick();
         check_all();
         check("hold_cnt8", 32'(c8), 32'd0);
      end
      release_rst();

      // CBITS=2 / CBITS=8 half-periods and wrap spacing
      assert_rst();
      release_rst();
      last_l2 = 0; last_l8 = 0; last_w2 = -1; last_w8 = -1;
      n_l2 = 0; n_l8 = 0; n_w2 = 0; n_w8 = 0;
      prev_l2 = l2; prev_l8 = l8;
      for (int i = 0; i < 600; i++) begin
         tick();
         if (l2 != prev_l2) begin
            check("half2", 32'(edges - last_l2), 32'd2);
            last_l2 = edges; n_l2++;
         end
         if (l8 != prev_l8) begin
            check("half8", 32'(edges - last_l8), 32'd128);
            last_l8 = edges; n_l8++;
         end
         if (w2) begin
            check("wrapgap2", 32'(edges - last_w2), 32'd4);
            last_w2 = edges; n_w2++;
         end
         if (w8) begin
            check("wrapgap8", 32'(edges - last_w8), 32'd256);
            last_w8 = edges; n_w8++;
         end
         prev_l2 = l2; prev_l8 = l8;
      end
      check("n_led2_toggles", 32'(n_l2), 32'd300);
      check("n_led8_toggles", 32'(n_l8), 32'd4);
      check("n_wrap2", 32'(n_w2), 32'd150);
      check("n_wrap8", 32'(n_w8), 32'd2);

      // Randomized run with occasional asynchronous resets
      assert_rst();
      release_rst();
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 24));
         if (r == 0) begin
            assert_rst();
            hold = int'($urandom_range(0, 3));
            for (int k = 0; k < hold; k++) begin
               tick();
               check_all();
            end
            release_rst();
         end else begin
            tick();
            check_all();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
